// File: rtl/branch_issue_ctrl_pkg.sv
// Shared definitions for the branch scheduler: data width, branch funct3
// encodings, request/result records and the next-PC helper.
package branch_issue_ctrl_pkg;

  localparam int XLEN      = 32;
  localparam int ROB_TAG_W = 5;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      rs1;
    logic [XLEN-1:0]      rs2;
    logic [XLEN-1:0]      imm;
    logic [2:0]           func;
    logic                 pred_taken;
    logic [XLEN-1:0]      pred_target;
    logic [ROB_TAG_W-1:0] tag;
  } branch_req_t;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] tag;
    logic                 taken;
    logic [XLEN-1:0]      target;
    logic                 mispredict;
  } branch_res_t;

  // Resolved next PC; plain modular add, overflow simply wraps.
  function automatic logic [XLEN-1:0] br_target(input logic            cond,
                                                input logic [XLEN-1:0] pc,
                                                input logic [XLEN-1:0] imm);
    return cond ? (pc + imm) : (pc + XLEN'(4));
  endfunction

endpackage

// File: rtl/branch_issue_ctrl_brcond.sv
// Branch condition evaluator. Reserved funct3 codes resolve as not-taken.
module brcond
  import branch_issue_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      func,
  output logic            cond
);

  // Compare operands according to funct3.
  always_comb begin
    cond = 1'b0;
    case (func)
      BR_BEQ:  cond = (rs1 == rs2);
      BR_BNE:  cond = (rs1 != rs2);
      BR_BLT:  cond = ($signed(rs1) <  $signed(rs2));
      BR_BGE:  cond = ($signed(rs1) >= $signed(rs2));
      BR_BLTU: cond = (rs1 <  rs2);
      BR_BGEU: cond = (rs1 >= rs2);
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_issue_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer,
// wrapping, and moves the pointer just past the winner when a grant is taken.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_d;
  logic [NUM_REQ-1:0] pick;
  logic               found;
  int                 win;
  int                 idx;

  // Search upward from the pointer for the first active request.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    win   = 0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (found) begin
      pick[win] = 1'b1;
    end
  end

  // Grant only when the consumer can take the winner; advance past it then.
  always_comb begin
    grant = enable ? pick : '0;
    ptr_d = ptr_q;
    if (enable && found) begin
      ptr_d = PTR_W'((win + 1) % NUM_REQ);
    end
  end

  // Pointer register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/branch_issue_ctrl.sv
// Shared branch unit scheduler: picks one ready branch RS entry round-robin,
// resolves it in the same cycle, and holds the result for the CDB/ROB on a
// valid/ready handshake. Also counts delivered mispredicts (saturating).
// TAG_W is expected to equal ROB_TAG_W, which sizes the result record.
module branch_issue_ctrl
  import branch_issue_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = ROB_TAG_W,
  parameter int CNT_W   = 16
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_pc,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_rs1,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_rs2,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_imm,
  input  logic [NUM_REQ-1:0][2:0]        req_func,
  input  logic [NUM_REQ-1:0]             req_pred_taken,
  input  logic [NUM_REQ-1:0][XLEN-1:0]   req_pred_target,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [TAG_W-1:0]               out_tag,
  output logic                           out_taken,
  output logic [XLEN-1:0]                out_target,
  output logic                           out_mispredict,
  output logic [CNT_W-1:0]               mispredict_cnt
);

  branch_req_t        req_vec [NUM_REQ];
  branch_req_t        win_req;
  branch_res_t        new_res;
  branch_res_t        res_d;
  branch_res_t        res_q;
  logic               out_valid_d;
  logic               out_valid_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] arb_grant;
  logic               accept;
  logic               cond;
  logic [XLEN-1:0]    target;

  // A new branch can issue when the output slot is free or draining this edge.
  assign accept = (!out_valid_q || out_ready) && !flush && (|req_valid);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req_valid),
    .enable  (accept),
    .grant   (arb_grant)
  );

  // The RS frees on grant, so never expose one while reset is asserted.
  assign grant = reset_n ? arb_grant : '0;

  // Gather per-entry fields into request records.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_vec[i].pc          = req_pc[i];
      req_vec[i].rs1         = req_rs1[i];
      req_vec[i].rs2         = req_rs2[i];
      req_vec[i].imm         = req_imm[i];
      req_vec[i].func        = req_func[i];
      req_vec[i].pred_taken  = req_pred_taken[i];
      req_vec[i].pred_target = req_pred_target[i];
      req_vec[i].tag         = ROB_TAG_W'(req_tag[i]);
    end
  end

  // One-hot select of the winning entry.
  always_comb begin
    win_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        win_req = req_vec[i];
      end
    end
  end

  brcond u_brcond (
    .rs1  (win_req.rs1),
    .rs2  (win_req.rs2),
    .func (win_req.func),
    .cond (cond)
  );

  // Resolve target and compare against the prediction.
  always_comb begin
    target             = br_target(cond, win_req.pc, win_req.imm);
    new_res.tag        = win_req.tag;
    new_res.taken      = cond;
    new_res.target     = target;
    new_res.mispredict = (cond != win_req.pred_taken) ||
                         (cond && (win_req.pred_target != target));
  end

  // Output slot: load on accept, empty on flush or drain, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      res_d       = new_res;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Count mispredicts actually handed over; a flush-cycle handshake is void.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid_q && out_ready && res_q.mispredict && !flush && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Result and counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_tag        = TAG_W'(res_q.tag);
  assign out_taken      = res_q.taken;
  assign out_target     = res_q.target;
  assign out_mispredict = res_q.mispredict;
  assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_issue_ctrl.sv
// Directed bench for branch_issue_ctrl. Counter width is reduced to 4 bits so
// the saturation boundary is reachable in a few cycles.
module tb_branch_issue_ctrl;

  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 5;
  localparam int CNT_W   = 4;
  localparam int XLEN    = 32;

  logic                          clock = 1'b0;
  logic                          reset_n;
  logic                          flush;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0][XLEN-1:0]  req_pc;
  logic [NUM_REQ-1:0][XLEN-1:0]  req_rs1;
  logic [NUM_REQ-1:0][XLEN-1:0]  req_rs2;
  logic [NUM_REQ-1:0][XLEN-1:0]  req_imm;
  logic [NUM_REQ-1:0][2:0]       req_func;
  logic [NUM_REQ-1:0]            req_pred_taken;
  logic [NUM_REQ-1:0][XLEN-1:0]  req_pred_target;
  logic [NUM_REQ-1:0][TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0]            grant;
  logic                          out_valid;
  logic                          out_ready;
  logic [TAG_W-1:0]              out_tag;
  logic                          out_taken;
  logic [XLEN-1:0]               out_target;
  logic                          out_mispredict;
  logic [CNT_W-1:0]              mispredict_cnt;

  int npass = 0;
  int nchk  = 0;

  branch_issue_ctrl #(
    .NUM_REQ (NUM_REQ),
    .TAG_W   (TAG_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .flush           (flush),
    .req_valid       (req_valid),
    .req_pc          (req_pc),
    .req_rs1         (req_rs1),
    .req_rs2         (req_rs2),
    .req_imm         (req_imm),
    .req_func        (req_func),
    .req_pred_taken  (req_pred_taken),
    .req_pred_target (req_pred_target),
    .req_tag         (req_tag),
    .grant           (grant),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_tag         (out_tag),
    .out_taken       (out_taken),
    .out_target      (out_target),
    .out_mispredict  (out_mispredict),
    .mispredict_cnt  (mispredict_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic set_entry(input int i, input logic [31:0] pc, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [31:0] imm,
                           input logic [2:0] func, input logic pt,
                           input logic [31:0] ptgt, input logic [4:0] tag);
    req_pc[i]          = pc;
    req_rs1[i]         = rs1;
    req_rs2[i]         = rs2;
    req_imm[i]         = imm;
    req_func[i]        = func;
    req_pred_taken[i]  = pt;
    req_pred_target[i] = ptgt;
    req_tag[i]         = tag;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [4:0] t,
                         input logic tk, input logic [31:0] tgt, input logic mp);
    chk({tag, "_valid"},  64'(out_valid),      64'(v));
    chk({tag, "_tag"},    64'(out_tag),        64'(t));
    chk({tag, "_taken"},  64'(out_taken),      64'(tk));
    chk({tag, "_target"}, 64'(out_target),     64'(tgt));
    chk({tag, "_misp"},   64'(out_mispredict), 64'(mp));
  endtask

  int rr_idx [5] = '{1, 2, 3, 0, 1};

  initial begin
    reset_n         = 1'b0;
    flush           = 1'b0;
    out_ready       = 1'b1;
    req_valid       = '0;
    req_pc          = '0;
    req_rs1         = '0;
    req_rs2         = '0;
    req_imm         = '0;
    req_func        = '0;
    req_pred_taken  = '0;
    req_pred_target = '0;
    req_tag         = '0;

    // Reset state, with a request pending so grant gating is exercised.
    set_entry(0, 32'h100, 32'd5, 32'd5, 32'h20, 3'b000, 1'b0, 32'h0, 5'd3);
    req_valid = 4'b0001;
    #2;
    chk("rst_grant", 64'(grant), 64'h0);
    chk_out("rst", 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
    chk("rst_cnt", 64'(mispredict_cnt), 64'h0);

    // Single BEQ request, predicted not-taken: taken, target 0x120, mispredict.
    @(negedge clock);
    reset_n = 1'b1;
    #1 chk("single_grant", 64'(grant), 64'h1);
    @(negedge clock);
    chk_out("single", 1'b1, 5'd3, 1'b1, 32'h120, 1'b1);
    chk("single_cnt_pre", 64'(mispredict_cnt), 64'h0);
    req_valid = 4'b0000;
    #1 chk("idle_grant", 64'(grant), 64'h0);
    @(negedge clock);
    chk("single_cnt", 64'(mispredict_cnt), 64'h1);
    chk("drain_valid", 64'(out_valid), 64'h0);

    // Round-robin with all four ready; pointer sits at 1 after the first grant.
    for (int i = 0; i < NUM_REQ; i++)
      set_entry(i, 32'(i * 32'h40), 32'h0, 32'h0, 32'h8, 3'b000, 1'b1,
                32'(i * 32'h40 + 32'h8), 5'(10 + i));
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_grant", 64'(grant), 64'(4'b0001 << rr_idx[k]));
      @(negedge clock);
      chk_out("rr", 1'b1, 5'(10 + rr_idx[k]), 1'b1, 32'(rr_idx[k] * 32'h40 + 32'h8), 1'b0);
    end

    // Backpressure: entry 1 result held, no grant while out_ready is low.
    out_ready = 1'b0;
    req_valid = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_grant", 64'(grant), 64'h0);
      @(negedge clock);
      chk_out("bp_hold", 1'b1, 5'd11, 1'b1, 32'h48, 1'b0);
    end
    out_ready = 1'b1;
    #1 chk("refill1_grant", 64'(grant), 64'b0100);
    @(negedge clock);
    chk_out("refill1", 1'b1, 5'd12, 1'b1, 32'h88, 1'b0);
    #1 chk("refill2_grant", 64'(grant), 64'b0010);
    @(negedge clock);
    chk_out("refill2", 1'b1, 5'd11, 1'b1, 32'h48, 1'b0);
    req_valid = 4'b0000;
    @(negedge clock);
    chk("bp_drain_valid", 64'(out_valid), 64'h0);
    chk("bp_cnt", 64'(mispredict_cnt), 64'h1);

    // Signed vs unsigned compare with rs1=-1, rs2=1.
    set_entry(0, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h10, 3'b100, 1'b1, 32'h210, 5'd20);
    req_valid = 4'b0001;
    #1 chk("blt_grant", 64'(grant), 64'h1);
    @(negedge clock);
    chk_out("blt", 1'b1, 5'd20, 1'b1, 32'h210, 1'b0);
    set_entry(0, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h10, 3'b110, 1'b1, 32'h210, 5'd21);
    @(negedge clock);
    chk_out("bltu", 1'b1, 5'd21, 1'b0, 32'h204, 1'b1);
    // Reserved funct3 resolves not-taken even with equal operands.
    set_entry(0, 32'h200, 32'h7, 32'h7, 32'h10, 3'b010, 1'b0, 32'h0, 5'd22);
    @(negedge clock);
    chk_out("rsvd", 1'b1, 5'd22, 1'b0, 32'h204, 1'b0);
    chk("rsvd_cnt", 64'(mispredict_cnt), 64'h2);
    set_entry(0, 32'h200, 32'h1, 32'h2, 32'h10, 3'b000, 1'b1, 32'h210, 5'd23);
    @(negedge clock);
    chk_out("bne_path", 1'b1, 5'd23, 1'b0, 32'h204, 1'b1);
    chk("pre_flush_cnt", 64'(mispredict_cnt), 64'h2);

    // Flush while a mispredict result is handshaking: not counted, slot empties.
    flush = 1'b1;
    #1 chk("flush_grant", 64'(grant), 64'h0);
    @(negedge clock);
    chk("flush_valid", 64'(out_valid), 64'h0);
    chk("flush_cnt", 64'(mispredict_cnt), 64'h2);
    flush = 1'b0;

    // Saturation: stream mispredicts until the 4-bit counter pins at 0xF.
    set_entry(0, 32'h200, 32'h1, 32'h2, 32'h10, 3'b000, 1'b1, 32'h210, 5'd24);
    for (int k = 0; k < 13; k++) @(negedge clock);
    chk("sat_cnt_e", 64'(mispredict_cnt), 64'hE);
    chk("sat_valid", 64'(out_valid), 64'h1);
    @(negedge clock);
    chk("sat_cnt_f", 64'(mispredict_cnt), 64'hF);
    @(negedge clock);
    chk("sat_cnt_hold", 64'(mispredict_cnt), 64'hF);
    req_valid = 4'b0000;
    @(negedge clock);
    chk("sat_cnt_final", 64'(mispredict_cnt), 64'hF);
    chk("sat_drain_valid", 64'(out_valid), 64'h0);

    // Asynchronous reset while a result is held.
    req_valid = 4'b0001;
    out_ready = 1'b0;
    @(negedge clock);
    chk("ar_loaded", 64'(out_valid), 64'h1);
    #2 reset_n = 1'b0;
    #1;
    chk_out("ar", 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
    chk("ar_cnt", 64'(mispredict_cnt), 64'h0);
    chk("ar_grant", 64'(grant), 64'h0);
    reset_n = 1'b1;
    #1 chk("ar_post_grant", 64'(grant), 64'h1);
    @(negedge clock);
    chk_out("ar_post", 1'b1, 5'd24, 1'b0, 32'h204, 1'b1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/branch_issue_ctrl.md
Name: branch_issue_ctrl

Overview:
- Scheduler for the shared branch functional unit in the Tomasulo back end.
- Arbitrates round-robin among NUM_REQ ready branch reservation-station entries and drives the winner's operands into one brcond instance.
- Computes the resolved target and mispredict flag, registers the result, and offers it to the CDB/ROB over a valid/ready handshake.
- Honours pipeline flush and keeps a saturating mispredict counter.

Parameters:
- NUM_REQ, 4, number of branch RS entries competing for the unit (>=2).
- TAG_W, 5, ROB tag width.
- CNT_W, 16, mispredict counter width.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  squash all in-flight branch work (mispredict recovery).
- req_valid  in  NUM_REQ  entry i ready to execute.
- req_pc  in  NUM_REQ x XLEN  branch PC per entry.
- req_rs1, req_rs2  in  NUM_REQ x XLEN  operand values.
- req_imm  in  NUM_REQ x XLEN  sign-extended B-immediate.
- req_func  in  NUM_REQ x 3  funct3.
- req_pred_taken  in  NUM_REQ  predicted direction.
- req_pred_target  in  NUM_REQ x XLEN  predicted target.
- req_tag  in  NUM_REQ x TAG_W  ROB tag.
- grant  out  NUM_REQ  one-hot issue acknowledge; the RS frees the entry on the same edge.
- out_valid  out  1  result held.
- out_ready  in  1  CDB accepts result.
- out_tag  out  TAG_W  ROB tag of result.
- out_taken  out  1  resolved direction.
- out_target  out  XLEN  resolved next PC.
- out_mispredict  out  1  resolution differs from prediction.
- mispredict_cnt  out  CNT_W  saturating count of delivered mispredicts.

Behaviour:
- Reset (async, reset_n=0): out_valid=0; out_tag, out_taken, out_target, out_mispredict, mispredict_cnt = 0; rr_ptr = 0; grant=0 (combinational, forced 0 while in reset).
- accept = (!out_valid || out_ready) && !flush && |req_valid.
- grant (combinational): first set req_valid bit searching from rr_ptr upward, wrapping modulo NUM_REQ. Only driven when accept=1, else all zero. At most one bit set.
- On an accept edge:
  - rr_ptr <= (granted index + 1) mod NUM_REQ; rr_ptr is otherwise unchanged.
  - The winner's fields go through brcond (combinational, same cycle), producing cond.
  - target = cond ? pc+imm : pc+4. XLEN-bit add, wrap-around, no overflow detection.
  - mispredict = (cond != pred_taken) || (cond && pred_target != target).
  - Registered: out_valid=1; out_tag, out_taken, out_target, out_mispredict updated.
- Latency: grant in cycle t gives out_valid in cycle t+1. Throughput is 1/cycle while out_ready=1.
- Stall: out_valid && !out_ready means all out_* hold stable, grant=0, rr_ptr holds.
- Drain without refill (out_ready=1, no req_valid): out_valid <= 0.
- Simultaneous drain and accept: the new result replaces the old in the same edge; no bubble.
- flush=1: grant=0 that cycle; out_valid <= 0 next edge regardless of out_ready. A result handshaking during a flush cycle is not counted. rr_ptr holds.
- mispredict_cnt increments on out_valid && out_ready && out_mispredict && !flush. It saturates at all-ones and never wraps.
- Reserved funct3 (010, 011): brcond yields cond=0. The branch is treated as not-taken: target = pc+4, mispredict per rule above.
- reset_n asserted mid-operation: immediate clear to reset values; the held result is lost.

Decomposition:
- sys_defs package/header holds:
  - the XLEN constant
  - the BR_BEQ..BR_BGEU funct3 localparams
  - a branch_req_t packed struct {pc, rs1, rs2, imm, func, pred_taken, pred_target, tag}
  - a branch_res_t struct {tag, taken, target, mispredict}
- Sub-modules:
  - brcond is instantiated unchanged.
  - One natural new sub-module: rr_arbiter (parameterised NUM_REQ, inputs req/enable, outputs one-hot grant, internal pointer). Reusable by other FU schedulers.

Test Plan:
- Reset then single request: req_valid=0001, pc=0x100, rs1=rs2=5, func=000, imm=0x20, pred_taken=0 -> grant=0001. Next cycle out_valid=1, out_taken=1, out_target=0x120, out_mispredict=1; mispredict_cnt=1 after handshake.
- Round-robin: req_valid=1111 held, out_ready=1 for 5 cycles -> grants 0001,0010,0100,1000,0001; out_tag sequence matches.
- Backpressure: out_ready=0 for 3 cycles with result held, req_valid=0110 -> grant=0 and out_* stable. out_ready=1 -> same-edge refill with entry 1, then entry 2.
- Signed/unsigned: rs1=0xFFFFFFFF, rs2=1; func=100 (BLT) -> taken; func=110 (BLTU) -> not-taken, target=pc+4.
- Flush: result valid, out_ready=1, flush=1, req_valid=0001 -> grant=0; out_valid=0 next cycle; mispredict_cnt unchanged.
- Saturation/async reset: preload 0xFFFE mispredicts, deliver 3 more -> counter stays 0xFFFF. Pulse reset_n low mid-cycle -> all outputs 0 immediately.
